// File: rtl/cracker_success_arbiter_pkg.sv
// rtl/cracker_success_arbiter_pkg.sv - shared types and defaults for the cracker success arbiter
package cracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_FOUND   = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam int DEF_N_CRACKERS = 4;
  localparam int DEF_KEY_W      = 32;
  localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/cracker_success_arbiter_if.sv
// rtl/cracker_success_arbiter_if.sv - host/cracker-array bundle for the success arbiter
interface cracker_success_arbiter_if
  import cracker_pkg::*;
#(
  parameter int N_CRACKERS = DEF_N_CRACKERS,
  parameter int KEY_W      = DEF_KEY_W,
  parameter int IDX_W      = $clog2(N_CRACKERS),
  parameter int CNT_W      = DEF_CNT_W
);
  logic                        start;
  logic [CNT_W-1:0]            timeout_cycles;
  logic [N_CRACKERS-1:0]       found;
  logic [N_CRACKERS*KEY_W-1:0] key_in;
  logic                        ack;
  logic                        busy;
  logic                        stop_crackers;
  logic                        success;
  logic                        fail;
  logic [IDX_W-1:0]            winner_idx;
  logic [KEY_W-1:0]            winner_key;
  logic                        multi_hit;
  logic [CNT_W-1:0]            elapsed;

  // Host / cracker-array side
  modport master (
    output start, timeout_cycles, found, key_in, ack,
    input  busy, stop_crackers, success, fail, winner_idx, winner_key, multi_hit, elapsed
  );

  // Arbiter side
  modport slave (
    input  start, timeout_cycles, found, key_in, ack,
    output busy, stop_crackers, success, fail, winner_idx, winner_key, multi_hit, elapsed
  );
endinterface

// File: rtl/cracker_success_arbiter_penc.sv
// rtl/cracker_success_arbiter_penc.sv - lowest-index-first priority encoder with multi-hit flag
module priority_encoder_n #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // Scan from the top down so the lowest set bit is the last (winning) assignment
  always_comb begin
    idx_o   = '0;
    any_o   = |req_i;
    multi_o = (req_i & (req_i - N'(1))) != '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cracker_success_arbiter.sv
// rtl/cracker_success_arbiter.sv - first-winner latch, stop broadcast and search timeout
module cracker_success_arbiter
  import cracker_pkg::*;
#(
  parameter int N_CRACKERS = DEF_N_CRACKERS,
  parameter int KEY_W      = DEF_KEY_W,
  parameter int IDX_W      = $clog2(N_CRACKERS),
  parameter int CNT_W      = DEF_CNT_W
) (
  input logic                      clk,
  input logic                      rst_n,
  cracker_success_arbiter_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             multi_q, multi_d;

  logic [IDX_W-1:0] hit_idx;
  logic             hit_any;
  logic             hit_multi;
  logic [KEY_W-1:0] key_sel;

  priority_encoder_n #(
    .N     (N_CRACKERS),
    .IDX_W (IDX_W)
  ) u_penc (
    .req_i   (bus.found),
    .idx_o   (hit_idx),
    .any_o   (hit_any),
    .multi_o (hit_multi)
  );

  // Winner key mux driven by the encoder index
  always_comb begin
    key_sel = '0;
    for (int i = 0; i < N_CRACKERS; i++) begin
      if (hit_idx == IDX_W'(i)) key_sel = bus.key_in[i*KEY_W +: KEY_W];
    end
  end

  // State and result registers; reset clears everything including the held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      elapsed_q <= '0;
      limit_q   <= '0;
      idx_q     <= '0;
      key_q     <= '0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      limit_q   <= limit_d;
      idx_q     <= idx_d;
      key_q     <= key_d;
      multi_q   <= multi_d;
    end
  end

  // Next state; found/key_in are only looked at in SEARCH, so strobes elsewhere are inert
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    limit_d   = limit_q;
    idx_d     = idx_q;
    key_d     = key_q;
    multi_d   = multi_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_SEARCH;
          elapsed_d = '0;
          limit_d   = bus.timeout_cycles;
          multi_d   = 1'b0;
        end
      end
      ST_SEARCH: begin
        if (hit_any) begin
          state_d = ST_FOUND;
          idx_d   = hit_idx;
          key_d   = key_sel;
          multi_d = hit_multi;
        end else if (limit_q != '0 && elapsed_q == limit_q - CNT_W'(1)) begin
          state_d   = ST_TIMEOUT;
          elapsed_d = limit_q;
        end else if (elapsed_q != '1) begin
          elapsed_d = elapsed_q + CNT_W'(1);
        end
      end
      ST_FOUND, ST_TIMEOUT: begin
        if (bus.ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy          = (state_q == ST_SEARCH);
  assign bus.success       = (state_q == ST_FOUND);
  assign bus.fail          = (state_q == ST_TIMEOUT);
  assign bus.stop_crackers = (state_q == ST_FOUND) || (state_q == ST_TIMEOUT);
  assign bus.winner_idx    = idx_q;
  assign bus.winner_key    = key_q;
  assign bus.multi_hit     = multi_q;
  assign bus.elapsed       = elapsed_q;

endmodule

// File: doc/cracker_success_arbiter.md
Name: cracker_success_arbiter

Overview:
Parametrised next-generation success detector for the parallel password-cracker array. It monitors N_CRACKERS found strobes and latches the index and key of the first winner, using fixed lowest-index-first priority. It broadcasts a stop to all crackers, enforces an optional cycle-count timeout, and holds the result until the host acknowledges it. It sits between the cracker array and the host/UART result path.

Parameters:
N_CRACKERS, 4, number of cracker channels (>=2)
KEY_W, 32, width of the candidate key reported by each cracker
IDX_W, $clog2(N_CRACKERS), width of the winner index
CNT_W, 32, width of the timeout limit and the elapsed-cycle counter

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; begins a search (honoured only in IDLE)
timeout_cycles  in  CNT_W  search limit in cycles; sampled on start; 0 = no timeout
found  in  N_CRACKERS  per-cracker match strobe; bit i = cracker i
key_in  in  N_CRACKERS*KEY_W  candidate keys; slice i = key_in[i*KEY_W +: KEY_W]
ack  in  1  host acknowledge; releases FOUND/TIMEOUT
busy  out  1  high in SEARCH
stop_crackers  out  1  high in FOUND and TIMEOUT
success  out  1  high in FOUND
fail  out  1  high in TIMEOUT
winner_idx  out  IDX_W  index of the latched winner
winner_key  out  KEY_W  key of the latched winner
multi_hit  out  1  more than one found bit was set in the capture cycle
elapsed  out  CNT_W  cycles spent in SEARCH; frozen on exit

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. All outputs are 0, including winner_idx, winner_key and elapsed. Reset in any state aborts the operation the same way.
- All outputs are registered. Status outputs are decoded from the state register.
- States: IDLE, SEARCH, FOUND, TIMEOUT.
- IDLE:
  - start=1 -> SEARCH on the next edge.
  - On that edge: elapsed<=0, limit<=timeout_cycles, multi_hit<=0.
  - winner_idx and winner_key keep their previous values until a new capture.
- SEARCH, evaluated each cycle:
  - found!=0 -> FOUND. winner_idx<=lowest set bit index; winner_key<=that key slice; multi_hit<=(popcount(found)>1).
  - Else, limit!=0 and elapsed==limit-1 -> TIMEOUT, elapsed<=limit.
  - Else elapsed<=elapsed+1, saturating at all-ones, no wrap.
  - found takes priority over timeout in the same cycle.
  - Latency: success rises 1 cycle after the found cycle. With limit=L, fail rises exactly L cycles after busy rises.
- FOUND / TIMEOUT:
  - Hold all outputs stable until ack=1, then -> IDLE on the next edge.
  - success, fail and stop_crackers drop on that edge. winner_* and elapsed remain readable in IDLE.
- Ignored inputs:
  - start outside IDLE.
  - found outside SEARCH (late strobes never overwrite a latched result).
  - ack outside FOUND/TIMEOUT.
  - start and ack both high in FOUND: ack wins, and start is ignored that cycle.
- found may be multi-cycle level or pulse; only the first SEARCH cycle with found!=0 counts.
- X on found or key_in while in IDLE must not propagate into outputs.

Decomposition:
- Shared package cracker_pkg holds:
  - state enum (IDLE=2'd0, SEARCH=2'd1, FOUND=2'd2, TIMEOUT=2'd3);
  - default N_CRACKERS and KEY_W constants;
  - a clog2 helper if needed by the toolflow.
- Sub-module priority_encoder_n (parameter N): combinational lowest-index-first encoder. Outputs: idx, any, multi. Key selection uses idx as a mux select.
- Counter and FSM stay in the top module.

Test Plan:
- Single hit: N=4, timeout 100. start, then found=4'b0100 on SEARCH cycle 5 with key_in slice2=32'hDEADBEEF. Required: success=1 next cycle, winner_idx=2, winner_key=DEADBEEF, elapsed=5, multi_hit=0, stop_crackers=1. After ack, returns to IDLE with success=0.
- Simultaneous hits: found=4'b1010 in one cycle. Required: winner_idx=1, key = slice1, multi_hit=1.
- Timeout: timeout_cycles=10, no found. Required: fail=1 exactly 10 cycles after busy rises, elapsed=10, success=0. found on the timeout-exit cycle still wins (FOUND, not TIMEOUT).
- Late strobe / no timeout: timeout_cycles=0, run 1000 cycles with busy held and no fail. Then found=4'b0001 with key A, followed by found=4'b1000 with key B while in FOUND. Required: winner_idx stays 0 and winner_key stays A.
- Reset mid-SEARCH: assert rst_n=0 for one edge during SEARCH. Required: all outputs 0 on the next edge, and a start pulse before reset release is ignored.
- Re-arm: after ack, a second start. Required: elapsed restarts from 0; the previous winner is held until the new capture; start and ack in the same cycle in FOUND leaves the block in IDLE.
